// File: rtl/simon_playback_seq.sv
// -----------------------------------------------------------------------------
// simon_playback_seq
//
// Replays the stored Simon colour pattern to the player. For each step from 0
// to len-1 it reads the colour from the sequence RAM and then lights the
// matching LED and enables the tone generator for an ON window. A dark GAP
// window follows. Both windows are timed in milliseconds by a prescaler. The
// prescaler is programmed with the number of clk cycles per millisecond.
//
// Ports
//   clk             system clock (25 MHz divided clock)
//   rst             asynchronous, active-high reset
//   ticks_per_milli clk cycles per millisecond (0 behaves as 1), read live
//   start           1-cycle playback request (ignored unless idle)
//   abort           1-cycle stop request, wins over start
//   len             steps to play, latched at accepted start, clamped to DEPTH
//   on_ms           ON window in ms, latched at accepted start (0 behaves as 1)
//   mem_addr        sequence RAM read address
//   mem_data        colour code, valid one cycle after mem_addr
//   led             one-hot LED drive (bit index = colour code)
//   tone_en         tone generator enable
//   tone_sel        colour code selecting the tone pitch
//   busy            high from the cycle after an accepted start until idle
//   done            1-cycle pulse after the last GAP window
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module simon_playback_seq #(
  parameter int ADDR_W = 5,
  parameter int GAP_MS = 200,
  parameter int MS_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  input  logic [MS_W-1:0]   on_ms,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic [3:0]        led,
  output logic              tone_en,
  output logic [1:0]        tone_sel,
  output logic              busy,
  output logic              done
);

  // DEPTH = 2**ADDR_W, expressed at the width of len.
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [MS_W:0]   GAP_V   = (MS_W + 1)'(GAP_MS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ON,
    GAP,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     lat_len_q, lat_len_d;
  logic [MS_W-1:0]     lat_on_q, lat_on_d;
  logic [15:0]         presc_q, presc_d;
  logic [15:0]         t_cur_q, t_cur_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          led_q, led_d;
  logic                tone_en_q, tone_en_d;
  logic [1:0]          tone_sel_q, tone_sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // One-hot decode of the colour currently arriving from the RAM.
  logic [3:0] colour_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_colour_dec
      assign colour_onehot[gi] = (mem_data == 2'(gi));
    end
  endgenerate

  // A ticks_per_milli value of 0 behaves as 1.
  logic [15:0] t_eff;
  assign t_eff = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;

  // t_cur_q holds the period in use for the current millisecond. It is
  // reloaded only when the prescaler restarts, so a change to
  // ticks_per_milli takes effect at the next wrap and not partway through
  // a millisecond.
  logic            ms_tick;
  logic [MS_W:0]   ms_inc;
  logic            on_hit;
  logic            gap_hit;
  logic            last_step;

  assign ms_tick   = (presc_q == (t_cur_q - 16'd1));
  assign ms_inc    = {1'b0, ms_q} + {{MS_W{1'b0}}, 1'b1};
  assign on_hit    = ms_tick && (ms_inc == {1'b0, lat_on_q});
  assign gap_hit   = ms_tick && (ms_inc == GAP_V);
  assign last_step = (({1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1}) == lat_len_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_len_d  = lat_len_q;
    lat_on_d   = lat_on_q;
    presc_d    = presc_q;
    t_cur_d    = t_cur_q;
    ms_d       = ms_q;
    mem_addr_d = mem_addr_q;
    led_d      = led_q;
    tone_en_d  = tone_en_q;
    tone_sel_d = tone_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // The prescaler and ms counter run in both timed windows.
    if (state_q == ON || state_q == GAP) begin
      if (ms_tick) begin
        presc_d = 16'd0;
        ms_d    = ms_inc[MS_W-1:0];
        t_cur_d = t_eff;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          lat_len_d = (len > DEPTH_V) ? DEPTH_V : len;
          lat_on_d  = (on_ms == '0) ? {{(MS_W-1){1'b0}}, 1'b1} : on_ms;
          idx_d     = '0;
          busy_d    = 1'b1;
          if (len == '0) begin
            // Nothing to play: go straight to the done pulse.
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d    = FETCH;
            mem_addr_d = '0;
          end
        end
      end

      FETCH: begin
        // mem_addr already points at idx. The RAM presents the data next cycle.
        state_d = LOAD;
      end

      LOAD: begin
        state_d    = ON;
        led_d      = colour_onehot;
        tone_en_d  = 1'b1;
        tone_sel_d = mem_data;
        presc_d    = 16'd0;
        ms_d       = '0;
        t_cur_d    = t_eff;
      end

      ON: begin
        if (on_hit) begin
          state_d   = GAP;
          led_d     = 4'd0;
          tone_en_d = 1'b0;
          presc_d   = 16'd0;
          ms_d      = '0;
        end
      end

      GAP: begin
        if (gap_hit) begin
          presc_d = 16'd0;
          ms_d    = '0;
          if (last_step) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            // lat_len never exceeds DEPTH, so idx stops at DEPTH-1.
            idx_d      = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_addr_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d    = FETCH;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_d   = IDLE;
      led_d     = 4'd0;
      tone_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lat_len_q  <= '0;
      lat_on_q   <= '0;
      presc_q    <= '0;
      t_cur_q    <= '0;
      ms_q       <= '0;
      mem_addr_q <= '0;
      led_q      <= '0;
      tone_en_q  <= 1'b0;
      tone_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_len_q  <= lat_len_d;
      lat_on_q   <= lat_on_d;
      presc_q    <= presc_d;
      t_cur_q    <= t_cur_d;
      ms_q       <= ms_d;
      mem_addr_q <= mem_addr_d;
      led_q      <= led_d;
      tone_en_q  <= tone_en_d;
      tone_sel_q <= tone_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign led      = led_q;
  assign tone_en  = tone_en_q;
  assign tone_sel = tone_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
